excp_commit_sched: RTL and testbench

//  Sequences exception, interrupt and ertn events from the WB commit point into the CSR unit.

---
 rtl/excp_commit_sched.sv | 116 +++++++++++
 tb/tb_excp_commit_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/excp_commit_sched.sv
// Commit-point event scheduler: turns a WB exception/interrupt/ertn into a one-cycle csr event,
// a timed pipeline flush and a held fetch redirect. Optional counters: `EXCP_STATS_EN.
module excp_commit_sched #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        cm_valid,
   input  logic [31:0] cm_pc,
   input  logic [6:0]  cm_excp,
   input  logic [31:0] cm_badva,
   output logic        cm_ready,
   input  logic        has_int,
   output logic [63:0] csr_vec,
   output logic [31:0] csr_pc,
   output logic [31:0] csr_badva,
   input  logic [31:0] csr_new_pc,
   output logic        flush,
   output logic        redir_valid,
   output logic [31:0] redir_pc,
   input  logic        redir_ready,
   output logic        busy,
   output logic [15:0] stat_excp,
   output logic [15:0] stat_int
);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

   state_t      state;
   logic [3:0]  flush_cnt;
   logic        event_take;
   logic [7:0]  event_vec;

   // An interrupt outranks ertn: ERA keeps the ertn pc so ertn re-executes after the handler.
   always_comb begin
      event_vec  = {cm_excp[6:1], cm_excp[0] & ~has_int, has_int};
      event_take = ~reset & (state == IDLE) & cm_valid & ~stall & ((|cm_excp) | has_int);
      csr_vec    = '0;
      csr_pc     = '0;
      csr_badva  = '0;
      if (event_take) begin
         csr_vec[7:0] = event_vec;
         csr_pc       = cm_pc;
         csr_badva    = cm_badva;
      end
   end

   // NOTE: control outputs are registered alongside the state, so they change only on edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         flush_cnt   <= '0;
         flush       <= 1'b0;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
         busy        <= 1'b0;
         cm_ready    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (event_take) begin
                  state     <= FLUSH;
                  flush_cnt <= FLUSH_INIT;
                  redir_pc  <= csr_new_pc;
                  flush     <= 1'b1;
                  busy      <= 1'b1;
                  cm_ready  <= 1'b0;
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt - 4'd1;
               if (flush_cnt <= 4'd1) begin
                  state       <= REDIR;
                  flush       <= 1'b0;
                  redir_valid <= 1'b1;
               end
            end
            REDIR: begin
               if (redir_ready) begin
                  state       <= IDLE;
                  redir_valid <= 1'b0;
                  busy        <= 1'b0;
                  cm_ready    <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               flush       <= 1'b0;
               redir_valid <= 1'b0;
               busy        <= 1'b0;
               cm_ready    <= 1'b1;
            end
         endcase
      end
   end

`ifdef EXCP_STATS_EN
   // Saturating event counters, bumped only in the single csr event cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_excp <= '0;
         stat_int  <= '0;
      end else if (event_take) begin
         if ((|event_vec[7:1]) && (stat_excp != 16'hFFFF)) stat_excp <= stat_excp + 16'd1;
         if (event_vec[0] && (stat_int != 16'hFFFF))       stat_int  <= stat_int + 16'd1;
      end
   end
`else
   assign stat_excp = '0;
   assign stat_int  = '0;
`endif

endmodule

// File: tb/tb_excp_commit_sched.sv
// Self-checking bench for excp_commit_sched: directed scenarios plus random traffic,
// all outputs compared every cycle against a cycle-count timeline model.
module tb_excp_commit_sched;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        cm_valid;
   logic [31:0] cm_pc;
   logic [6:0]  cm_excp;
   logic [31:0] cm_badva;
   logic        cm_ready;
   logic        has_int;
   logic [63:0] csr_vec;
   logic [31:0] csr_pc;
   logic [31:0] csr_badva;
   logic [31:0] csr_new_pc;
   logic        flush;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        redir_ready;
   logic        busy;
   logic [15:0] stat_excp;
   logic [15:0] stat_int;

   int checks   = 0;
   int failures = 0;

   // Timeline model: an event starts a sequence; k counts cycles since the event cycle.
   bit          m_seq;
   int          m_k;
   logic [31:0] m_pc;
   int unsigned m_se;
   int unsigned m_si;

   excp_commit_sched #(.FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .stall(stall), .cm_valid(cm_valid), .cm_pc(cm_pc),
      .cm_excp(cm_excp), .cm_badva(cm_badva), .cm_ready(cm_ready), .has_int(has_int),
      .csr_vec(csr_vec), .csr_pc(csr_pc), .csr_badva(csr_badva), .csr_new_pc(csr_new_pc),
      .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
      .busy(busy), .stat_excp(stat_excp), .stat_int(stat_int)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_event();
      return !m_seq && !reset && cm_valid && !stall && (cm_excp != 7'd0 || has_int);
   endfunction

   function automatic logic [63:0] m_vec();
      logic [63:0] v = '0;
      if (m_event()) begin
         v[0]   = has_int;
         v[1]   = cm_excp[0] & ~has_int;
         v[7:2] = cm_excp[6:1];
      end
      return v;
   endfunction

   task automatic model_check();
      bit ev = m_event();
      bit exp_redir = m_seq && (m_k > FC);
      check("cm_ready", cm_ready, !m_seq);
      check("busy", busy, m_seq);
      check("flush", flush, m_seq && (m_k <= FC));
      check("redir_valid", redir_valid, exp_redir);
      if (exp_redir) check("redir_pc", redir_pc, m_pc);
      check("csr_vec", csr_vec, m_vec());
      check("csr_pc", csr_pc, ev ? cm_pc : 32'd0);
      check("csr_badva", csr_badva, ev ? cm_badva : 32'd0);
`ifdef EXCP_STATS_EN
      check("stat_excp", stat_excp, 16'(m_se));
      check("stat_int", stat_int, 16'(m_si));
`else
      check("stat_excp", stat_excp, 16'd0);
      check("stat_int", stat_int, 16'd0);
`endif
   endtask

   task automatic model_step();
      logic [63:0] v = m_vec();
      if (reset) begin
         m_seq = 0;
         m_se  = 0;
         m_si  = 0;
      end else if (m_event()) begin
         if (v[7:1] != 7'd0 && m_se < 32'hFFFF) m_se++;
         if (v[0] && m_si < 32'hFFFF) m_si++;
         m_seq = 1;
         m_k   = 1;
         m_pc  = csr_new_pc;
      end else if (m_seq) begin
         if (m_k > FC && redir_ready) m_seq = 0;
         else m_k++;
      end
   endtask

   task automatic tick();
      model_check();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] ex,
                        input logic [31:0] bva, input logic hi, input logic st,
                        input logic [31:0] npc, input logic rdy);
      cm_valid = v; cm_pc = pc; cm_excp = ex; cm_badva = bva;
      has_int = hi; stall = st; csr_new_pc = npc; redir_ready = rdy;
      #1;
   endtask

   task automatic idle_inputs(input logic rdy);
      drive(1'b0, 32'd0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0, rdy);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      idle_inputs(1'b1);
      while (!cm_ready && n < 40) begin
         tick();
         n++;
      end
      check(tag, cm_ready, 1'b1);
   endtask

   initial begin
      int n;
      int fl;
      logic [31:0] held_pc;
      m_seq = 0; m_k = 0; m_pc = '0; m_se = 0; m_si = 0;

      // Reset state
      reset = 1'b1;
      idle_inputs(1'b0);
      @(posedge clk);
      #1;
      check("rst_cm_ready", cm_ready, 1'b1);
      check("rst_redir_pc", redir_pc, 32'd0);
      tick();
      reset = 1'b0;

      // 1: syscall, flush for FC cycles, redirect, back to idle FC+2 cycles after the event
      drive(1'b1, 32'h1c000100, 7'b0000010, 32'd0, 1'b0, 1'b0, 32'h1c008000, 1'b1);
      check("t1_vec", csr_vec, 64'h04);
      check("t1_pc", csr_pc, 32'h1c000100);
      tick();
      idle_inputs(1'b1);
      n = 1; fl = 0;
      while (!cm_ready && n < 20) begin
         if (flush) fl++;
         if (redir_valid) check("t1_redir_pc", redir_pc, 32'h1c008000);
         tick();
         n++;
      end
      check("t1_flush_cycles", fl, FC);
      check("t1_event_to_idle", n, FC + 2);

      // 2: ale with a bad VA
      drive(1'b1, 32'h1c000104, 7'b1000000, 32'h00000003, 1'b0, 1'b0, 32'h1c008000, 1'b1);
      check("t2_vec", csr_vec, 64'h80);
      check("t2_badva", csr_badva, 32'h3);
      tick();
      wait_idle("t2_idle");

      // 3: pending interrupt waits for a commit
      drive(1'b0, 32'h1c000108, 7'd0, 32'd0, 1'b1, 1'b0, 32'h1c008000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("t3_no_event", csr_vec, 64'h0);
         tick();
      end
      drive(1'b1, 32'h1c000108, 7'd0, 32'd0, 1'b1, 1'b0, 32'h1c008000, 1'b1);
      check("t3_vec", csr_vec, 64'h01);
      tick();
      wait_idle("t3_idle");

      // 4: interrupt suppresses ertn; ertn alone redirects to era
      drive(1'b1, 32'h1c00010c, 7'b0000001, 32'd0, 1'b1, 1'b0, 32'h1c008000, 1'b1);
      check("t4_int_vec", csr_vec, 64'h01);
      tick();
      wait_idle("t4a_idle");
      drive(1'b1, 32'h1c00800c, 7'b0000001, 32'd0, 1'b0, 1'b0, 32'h1c000200, 1'b1);
      check("t4_ertn_vec", csr_vec, 64'h02);
      tick();
      idle_inputs(1'b1);
      n = 0;
      while (!redir_valid && n < 20) begin tick(); n++; end
      check("t4_redir_pc", redir_pc, 32'h1c000200);
      wait_idle("t4b_idle");

      // 5: redirect held while fetch stalls; new commits ignored
      drive(1'b1, 32'h1c000110, 7'b0000100, 32'd0, 1'b0, 1'b0, 32'h1c00a000, 1'b0);
      tick();
      idle_inputs(1'b0);
      n = 0;
      while (!redir_valid && n < 20) begin tick(); n++; end
      check("t5_redir_seen", redir_valid, 1'b1);
      held_pc = redir_pc;
      drive(1'b1, 32'h1c000114, 7'b0000010, 32'd0, 1'b0, 1'b0, 32'h1c00b000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("t5_redir_valid", redir_valid, 1'b1);
         check("t5_redir_pc", redir_pc, held_pc);
         check("t5_cm_ready", cm_ready, 1'b0);
         check("t5_vec", csr_vec, 64'h0);
         tick();
      end
      wait_idle("t5_idle");

      // 6: reset in the second flush cycle
      drive(1'b1, 32'h1c000118, 7'b0000010, 32'd0, 1'b0, 1'b0, 32'h1c008000, 1'b1);
      tick();
      idle_inputs(1'b1);
      tick();
      check("t6_flush2", flush, 1'b1);
      reset = 1'b1;
      #1;
      tick();
      reset = 1'b0;
      check("t6_flush", flush, 1'b0);
      check("t6_redir_valid", redir_valid, 1'b0);
      check("t6_cm_ready", cm_ready, 1'b1);
      check("t6_stat_excp", stat_excp, 16'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         drive(1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0,
               $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
               $urandom, 1'($urandom_range(0, 1)));
         tick();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
